apb_deviceinfo_reader: RTL and testbench

APB requester that fetches the device information block (IDCODE, 64-bit die serial, USERCODE) over APB and presents it as stable parallel outputs. It starts automatically after reset and can be retriggered. It polls the completer's status register until both valid flags are set, then reads the four data registers in a fixed order. It sits between an APB bridge port attached to the device-info completer and logic that needs the values, such as a management register file or a MAC-address generator.

---
 rtl/apb_deviceinfo_reader_if.sv | 41 ++++
 rtl/apb_deviceinfo_reader.sv | 241 ++++++++++++++++++++++++
 tb/tb_apb_deviceinfo_reader.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/apb_deviceinfo_reader_if.sv
// apb_if: 32-bit-capable APB bus bundle shared by the device-info requester
// and its completer.
// Ports:
//   pclk      - bus clock
//   preset_n  - asynchronous active-low bus reset
// Modports:
//   requester - drives the address, control and write sidebands; receives
//               pready, prdata and pslverr
//   completer - the mirror image of requester
interface apb_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int USER_WIDTH = 1
) (
  input logic pclk,
  input logic preset_n
);
  logic [ADDR_WIDTH-1:0]   paddr;
  logic [2:0]              pprot;
  logic                    psel;
  logic                    penable;
  logic                    pwrite;
  logic [DATA_WIDTH-1:0]   pwdata;
  logic [DATA_WIDTH/8-1:0] pstrb;
  logic [USER_WIDTH-1:0]   pauser;
  logic [USER_WIDTH-1:0]   pwuser;
  logic                    pready;
  logic [DATA_WIDTH-1:0]   prdata;
  logic                    pslverr;

  modport requester (
    input  pclk, preset_n, pready, prdata, pslverr,
    output paddr, pprot, psel, penable, pwrite, pwdata, pstrb, pauser, pwuser
  );

  modport completer (
    input  pclk, preset_n, paddr, pprot, psel, penable, pwrite, pwdata, pstrb,
           pauser, pwuser,
    output pready, prdata, pslverr
  );
endinterface

// File: rtl/apb_deviceinfo_reader.sv
// apb_deviceinfo_reader: fetches IDCODE, the 64-bit die serial and USERCODE
// from a device-info completer over APB and holds them as stable outputs.
// Ports:
//   apb         - APB requester port (clock and reset come from here)
//   refresh     - one-cycle pulse restarting the fetch when not busy
//   idcode      - captured IDCODE
//   die_serial  - captured serial, {SERIAL_0, SERIAL_1}
//   usercode    - captured USERCODE
//   info_valid  - outputs come from one completed sequence
//   busy        - a fetch sequence is in progress
//   err         - sticky failure flag for the last sequence
//   err_code    - 0 none, 1 pslverr, 2 timeout, 3 poll limit
module apb_deviceinfo_reader #(
  parameter int unsigned           ADDR_WIDTH    = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR     = '0,
  parameter int unsigned           POLL_INTERVAL = 256,
  parameter int unsigned           MAX_POLLS     = 1024,
  parameter int unsigned           TIMEOUT       = 64
) (
  apb_if.requester    apb,
  input  logic        refresh,
  output logic [31:0] idcode,
  output logic [63:0] die_serial,
  output logic [31:0] usercode,
  output logic        info_valid,
  output logic        busy,
  output logic        err,
  output logic [1:0]  err_code
);

  if ($bits(apb.prdata) != 32) begin : g_width_check
    $error("apb_deviceinfo_reader requires a 32-bit APB data bus");
  end
  if (POLL_INTERVAL < 1) begin : g_poll_check
    $error("apb_deviceinfo_reader requires POLL_INTERVAL >= 1");
  end

  typedef enum logic [2:0] {IDLE, SETUP, ACCESS, WAIT, DONE, FAIL} state_e;
  typedef enum logic [2:0] {
    REG_STATUS, REG_IDCODE, REG_SERIAL0, REG_SERIAL1, REG_USERCODE
  } reg_e;

  function automatic logic [7:0] reg_offset(input reg_e r);
    case (r)
      REG_IDCODE:   return 8'h04;
      REG_SERIAL0:  return 8'h0c;
      REG_SERIAL1:  return 8'h10;
      REG_USERCODE: return 8'h14;
      default:      return 8'h00;
    endcase
  endfunction

  state_e                state, state_d;
  reg_e                  idx, idx_d;
  logic [1:0]            fail_code;
  logic [31:0]           poll_cnt, wait_cnt, tmo_cnt;
  logic [ADDR_WIDTH-1:0] paddr_q;
  logic [31:0]           sh_idcode, sh_serial0, sh_serial1, sh_usercode;
  logic                  busy_q;
  logic                  psel_c, penable_c, busy_c;
  logic                  xfer_ok;

  assign xfer_ok = (state == ACCESS) && apb.pready && !apb.pslverr;

  // State register; reset pulls psel/penable low asynchronously via IDLE.
  always_ff @(posedge apb.pclk or negedge apb.preset_n) begin
    if (!apb.preset_n) begin
      state <= IDLE;
      idx   <= REG_STATUS;
    end else begin
      state <= state_d;
      idx   <= idx_d;
    end
  end

  // Next-state logic, including failure cause selection.
  always_comb begin
    state_d   = state;
    idx_d     = idx;
    fail_code = 2'd0;
    unique case (state)
      IDLE: begin
        state_d = SETUP;
        idx_d   = REG_STATUS;
      end
      SETUP: state_d = ACCESS;
      ACCESS: begin
        if (apb.pready) begin
          if (apb.pslverr) begin
            state_d   = FAIL;
            fail_code = 2'd1;
          end else begin
            case (idx)
              REG_STATUS: begin
                if (apb.prdata[1:0] == 2'b11) begin
                  state_d = SETUP;
                  idx_d   = REG_IDCODE;
                end else if (poll_cnt + 32'd1 >= MAX_POLLS) begin
                  state_d   = FAIL;
                  fail_code = 2'd3;
                end else begin
                  state_d = WAIT;
                end
              end
              REG_IDCODE: begin
                state_d = SETUP;
                idx_d   = REG_SERIAL0;
              end
              REG_SERIAL0: begin
                state_d = SETUP;
                idx_d   = REG_SERIAL1;
              end
              REG_SERIAL1: begin
                state_d = SETUP;
                idx_d   = REG_USERCODE;
              end
              REG_USERCODE: state_d = DONE;
              default:      state_d = IDLE;
            endcase
          end
        end else if (tmo_cnt + 32'd1 >= TIMEOUT) begin
          // Deliberate abort: psel drops without a completing pready.
          state_d   = FAIL;
          fail_code = 2'd2;
        end
      end
      WAIT: begin
        if (wait_cnt + 32'd1 >= POLL_INTERVAL) begin
          state_d = SETUP;
          idx_d   = REG_STATUS;
        end
      end
      DONE, FAIL: begin
        if (refresh) begin
          state_d = SETUP;
          idx_d   = REG_STATUS;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Bus strobes and busy; busy covers the IDLE cycle right after reset release.
  always_comb begin
    psel_c    = 1'b0;
    penable_c = 1'b0;
    busy_c    = busy_q;
    case (state)
      IDLE:    busy_c = apb.preset_n;
      SETUP:   psel_c = 1'b1;
      ACCESS: begin
        psel_c    = 1'b1;
        penable_c = 1'b1;
      end
      default: ;
    endcase
  end

  assign apb.psel    = psel_c;
  assign apb.penable = penable_c;
  assign apb.paddr   = paddr_q;
  assign apb.pwrite  = 1'b0;
  assign apb.pwdata  = '0;
  assign apb.pstrb   = '0;
  assign apb.pprot   = '0;
  assign apb.pauser  = '0;
  assign apb.pwuser  = '0;
  assign busy        = busy_c;

  // Counters, address, shadow capture and the published outputs. Outputs are
  // only rewritten while in DONE so consumers never see a mixed set.
  always_ff @(posedge apb.pclk or negedge apb.preset_n) begin
    if (!apb.preset_n) begin
      poll_cnt    <= '0;
      wait_cnt    <= '0;
      tmo_cnt     <= '0;
      paddr_q     <= '0;
      sh_idcode   <= '0;
      sh_serial0  <= '0;
      sh_serial1  <= '0;
      sh_usercode <= '0;
      idcode      <= '0;
      die_serial  <= '0;
      usercode    <= '0;
      info_valid  <= 1'b0;
      busy_q      <= 1'b0;
      err         <= 1'b0;
      err_code    <= 2'd0;
    end else begin
      if (state_d == SETUP && state != SETUP) begin
        paddr_q <= BASE_ADDR + ADDR_WIDTH'(reg_offset(idx_d));
      end

      if (state == SETUP) begin
        tmo_cnt <= '0;
      end else if (state == ACCESS && !apb.pready) begin
        tmo_cnt <= tmo_cnt + 32'd1;
      end

      wait_cnt <= (state == WAIT) ? wait_cnt + 32'd1 : '0;

      if (state == IDLE || ((state == DONE || state == FAIL) && refresh)) begin
        poll_cnt <= '0;
      end else if (xfer_ok && idx == REG_STATUS && apb.prdata[1:0] != 2'b11) begin
        poll_cnt <= poll_cnt + 32'd1;
      end

      if (xfer_ok) begin
        case (idx)
          REG_IDCODE:   sh_idcode   <= apb.prdata;
          REG_SERIAL0:  sh_serial0  <= apb.prdata;
          REG_SERIAL1:  sh_serial1  <= apb.prdata;
          REG_USERCODE: sh_usercode <= apb.prdata;
          default: ;
        endcase
      end

      if (state == IDLE) begin
        busy_q <= 1'b1;
      end

      if (state == DONE) begin
        idcode     <= sh_idcode;
        die_serial <= {sh_serial0, sh_serial1};
        usercode   <= sh_usercode;
        info_valid <= 1'b1;
        busy_q     <= refresh;
        err        <= 1'b0;
        err_code   <= 2'd0;
      end else if (state_d == FAIL && state != FAIL) begin
        busy_q   <= 1'b0;
        err      <= 1'b1;
        err_code <= fail_code;
      end else if (state == FAIL && refresh) begin
        busy_q <= 1'b1;
        err    <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_apb_deviceinfo_reader.sv
// tb_apb_deviceinfo_reader: directed bench for apb_deviceinfo_reader with a
// configurable behavioural device-info completer (wait states, pslverr,
// never-ready, a number of not-ready STATUS replies) and a bus monitor.
// Ports: none.
module tb_apb_deviceinfo_reader;

  logic        pclk;
  logic        preset_n;
  logic        refresh;
  logic [31:0] idcode;
  logic [63:0] die_serial;
  logic [31:0] usercode;
  logic        info_valid;
  logic        busy;
  logic        err;
  logic [1:0]  err_code;

  apb_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .USER_WIDTH(1)) apb (
    .pclk(pclk),
    .preset_n(preset_n)
  );

  apb_deviceinfo_reader #(
    .ADDR_WIDTH(32),
    .BASE_ADDR(32'h0),
    .POLL_INTERVAL(4),
    .MAX_POLLS(6),
    .TIMEOUT(8)
  ) dut (
    .apb(apb),
    .refresh(refresh),
    .idcode(idcode),
    .die_serial(die_serial),
    .usercode(usercode),
    .info_valid(info_valid),
    .busy(busy),
    .err(err),
    .err_code(err_code)
  );

  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  // Completer configuration, written only by the main test process.
  int          c_bad;
  logic [31:0] c_id, c_s0, c_s1, c_user;
  logic [7:0]  c_ws_off, c_err_off;
  int          c_ws;
  bit          c_hang;

  int          acc_cnt;
  int          status_reads;
  logic [7:0]  off;
  logic [31:0] rd;
  int          need_ws;

  assign off = apb.paddr[7:0];

  always_comb begin
    rd = 32'h0;
    case (off)
      8'h00:   rd = (status_reads < c_bad) ? 32'h1 : 32'h3;
      8'h04:   rd = c_id;
      8'h0c:   rd = c_s0;
      8'h10:   rd = c_s1;
      8'h14:   rd = c_user;
      default: rd = 32'hdeaddead;
    endcase
    need_ws = (off == c_ws_off) ? c_ws : 0;
  end

  assign apb.prdata  = rd;
  assign apb.pready  = apb.psel && apb.penable && !c_hang && (acc_cnt >= need_ws);
  assign apb.pslverr = apb.pready && (off == c_err_off);

  always @(posedge pclk or negedge preset_n) begin
    if (!preset_n) begin
      acc_cnt      <= 0;
      status_reads <= 0;
    end else begin
      acc_cnt <= (apb.psel && apb.penable && !apb.pready) ? acc_cnt + 1 : 0;
      if (apb.psel && apb.penable && apb.pready && off == 8'h00) begin
        status_reads <= status_reads + 1;
      end
    end
  end

  // Bus monitor: SETUP addresses, longest ACCESS run, paddr stability.
  logic [31:0] setup_q[$];
  int          acc_len, max_acc;
  logic [31:0] acc_addr;
  bit          addr_unstable;

  always @(negedge pclk) begin
    if (!preset_n) begin
      setup_q.delete();
      acc_len       = 0;
      max_acc       = 0;
      addr_unstable = 0;
    end else begin
      if (apb.psel && !apb.penable) setup_q.push_back(apb.paddr);
      if (apb.psel && apb.penable) begin
        if (acc_len == 0) acc_addr = apb.paddr;
        else if (apb.paddr != acc_addr) addr_unstable = 1;
        acc_len++;
        if (acc_len > max_acc) max_acc = acc_len;
      end else begin
        acc_len = 0;
      end
    end
  end

  int n_total;
  int n_bad;

  task automatic check_output(input string name, input logic [63:0] act,
                              input logic [63:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_completer(input int bad, input logic [31:0] id,
                               input logic [31:0] s0, input logic [31:0] s1,
                               input logic [31:0] user, input logic [7:0] ws_off,
                               input int ws, input logic [7:0] err_off,
                               input bit hang);
    c_bad = bad; c_id = id; c_s0 = s0; c_s1 = s1; c_user = user;
    c_ws_off = ws_off; c_ws = ws; c_err_off = err_off; c_hang = hang;
  endtask

  task automatic do_reset();
    @(negedge pclk);
    preset_n = 1'b0;
    refresh  = 1'b0;
    repeat (2) @(negedge pclk);
    preset_n = 1'b1;
  endtask

  // Cycles after reset release (or a refresh edge) until info_valid or err.
  task automatic wait_for_end(input int limit, output int cyc);
    cyc = 0;
    while (cyc < limit) begin
      @(posedge pclk);
      #1;
      cyc++;
      if (info_valid || err) break;
    end
  endtask

  task automatic pulse_refresh();
    @(negedge pclk);
    refresh = 1'b1;
    @(posedge pclk);
    #1;
  endtask

  typedef struct {
    string       name;
    int          bad;
    logic [31:0] id, s0, s1, user;
    logic [7:0]  ws_off;
    int          ws;
    logic [7:0]  err_off;
    bit          hang;
    int          exp_cycle;
    bit          exp_valid;
    logic [1:0]  exp_code;
    int          exp_acc;
    int          exp_setups;
  } vec_t;

  vec_t vecs[7];

  task automatic apply_stimulus(input vec_t v);
    int          cyc;
    logic [31:0] exp_addr[5];
    set_completer(v.bad, v.id, v.s0, v.s1, v.user, v.ws_off, v.ws, v.err_off, v.hang);
    do_reset();
    wait_for_end(200, cyc);
    check_output({v.name, ".cycle"}, 64'(cyc), 64'(v.exp_cycle));
    check_output({v.name, ".info_valid"}, 64'(info_valid), 64'(v.exp_valid));
    check_output({v.name, ".err"}, 64'(err), 64'(!v.exp_valid));
    check_output({v.name, ".err_code"}, 64'(err_code), 64'(v.exp_code));
    check_output({v.name, ".busy"}, 64'(busy), 64'h0);
    check_output({v.name, ".idcode"}, 64'(idcode), v.exp_valid ? 64'(v.id) : 64'h0);
    check_output({v.name, ".die_serial"}, die_serial,
                 v.exp_valid ? {v.s0, v.s1} : 64'h0);
    check_output({v.name, ".usercode"}, 64'(usercode), v.exp_valid ? 64'(v.user) : 64'h0);
    @(negedge pclk);
    check_output({v.name, ".max_access"}, 64'(max_acc), 64'(v.exp_acc));
    check_output({v.name, ".paddr_stable"}, 64'(addr_unstable), 64'h0);
    check_output({v.name, ".setups"}, 64'(setup_q.size()), 64'(v.exp_setups));
    if (v.exp_valid && setup_q.size() >= 5) begin
      exp_addr = '{32'h00, 32'h04, 32'h0c, 32'h10, 32'h14};
      for (int i = 0; i < 5; i++) begin
        check_output($sformatf("%s.paddr%0d", v.name, i),
                     64'(setup_q[setup_q.size() - 5 + i]), 64'(exp_addr[i]));
      end
    end
  endtask

  initial begin
    int cyc;
    int n_before;
    n_total  = 0;
    n_bad    = 0;
    refresh  = 1'b0;
    preset_n = 1'b1;
    set_completer(0, 32'h13631093, 32'h0000adbe, 32'hefc0def0, 32'hcafebabe,
                  8'hff, 0, 8'hff, 1'b0);

    //                name          bad id            s0            s1            user          wsoff ws erroff hang cyc valid code acc setups
    vecs[0] = '{"normal",     0,   32'h13631093, 32'h0000adbe, 32'hefc0def0, 32'hcafebabe, 8'hff, 0, 8'hff, 0, 12, 1, 2'd0, 1, 5};
    vecs[1] = '{"poll3",      3,   32'h13631093, 32'h0000adbe, 32'hefc0def0, 32'hcafebabe, 8'hff, 0, 8'hff, 0, 30, 1, 2'd0, 1, 8};
    vecs[2] = '{"ws_id",      0,   32'h13631093, 32'h0000adbe, 32'hefc0def0, 32'hcafebabe, 8'h04, 3, 8'hff, 0, 15, 1, 2'd0, 4, 5};
    vecs[3] = '{"slverr",     0,   32'h13631093, 32'h0000adbe, 32'hefc0def0, 32'hcafebabe, 8'hff, 0, 8'h10, 0,  9, 0, 2'd1, 1, 4};
    vecs[4] = '{"timeout",    0,   32'h13631093, 32'h0000adbe, 32'hefc0def0, 32'hcafebabe, 8'hff, 0, 8'hff, 1, 10, 0, 2'd2, 8, 1};
    vecs[5] = '{"poll_limit", 100, 32'h13631093, 32'h0000adbe, 32'hefc0def0, 32'hcafebabe, 8'hff, 0, 8'hff, 0, 33, 0, 2'd3, 1, 6};
    vecs[6] = '{"ws_user",    0,   32'h0ba00477, 32'h11223344, 32'h55667788, 32'h9abcdef0, 8'h14, 1, 8'hff, 0, 13, 1, 2'd0, 2, 5};

    // Reset values while reset is held.
    #2 preset_n = 1'b0;
    #10;
    check_output("rst.psel", 64'(apb.psel), 64'h0);
    check_output("rst.penable", 64'(apb.penable), 64'h0);
    check_output("rst.paddr", 64'(apb.paddr), 64'h0);
    check_output("rst.idcode", 64'(idcode), 64'h0);
    check_output("rst.die_serial", die_serial, 64'h0);
    check_output("rst.usercode", 64'(usercode), 64'h0);
    check_output("rst.info_valid", 64'(info_valid), 64'h0);
    check_output("rst.busy", 64'(busy), 64'h0);
    check_output("rst.err", 64'(err), 64'h0);
    check_output("rst.err_code", 64'(err_code), 64'h0);

    for (int i = 0; i < 7; i++) apply_stimulus(vecs[i]);

    // Literal serial value from the reference completer contents.
    apply_stimulus(vecs[0]);
    check_output("normal.serial_literal", die_serial, 64'h0000adbeefc0def0);

    // Refresh after DONE: old values held until the new DONE, second pulse ignored.
    set_completer(0, 32'h13631093, 32'h0000adbe, 32'hefc0def0, 32'h12345678,
                  8'hff, 0, 8'hff, 1'b0);
    n_before = setup_q.size();
    pulse_refresh();
    check_output("refresh.psel_next", 64'(apb.psel), 64'h1);
    check_output("refresh.busy", 64'(busy), 64'h1);
    for (int k = 2; k <= 12; k++) begin
      @(negedge pclk);
      refresh = (k == 4);
      @(posedge pclk);
      #1;
      if (k == 6) begin
        check_output("refresh.mid_valid", 64'(info_valid), 64'h1);
        check_output("refresh.mid_usercode", 64'(usercode), 64'hcafebabe);
      end
      if (k == 11) check_output("refresh.old_usercode", 64'(usercode), 64'hcafebabe);
      if (k == 12) begin
        check_output("refresh.new_usercode", 64'(usercode), 64'h12345678);
        check_output("refresh.busy_done", 64'(busy), 64'h0);
      end
    end
    @(negedge pclk);
    refresh = 1'b0;
    check_output("refresh.setups", 64'(setup_q.size() - n_before), 64'h5);

    // Reset asserted mid-ACCESS returns everything to reset values at once.
    pulse_refresh();
    @(negedge pclk);
    refresh = 1'b0;
    cyc = 0;
    while (!apb.penable && cyc < 20) begin
      @(posedge pclk);
      #1;
      cyc++;
    end
    check_output("midrst.in_access", 64'(apb.penable), 64'h1);
    #1 preset_n = 1'b0;
    #1;
    check_output("midrst.psel", 64'(apb.psel), 64'h0);
    check_output("midrst.penable", 64'(apb.penable), 64'h0);
    check_output("midrst.idcode", 64'(idcode), 64'h0);
    check_output("midrst.usercode", 64'(usercode), 64'h0);
    check_output("midrst.info_valid", 64'(info_valid), 64'h0);
    check_output("midrst.busy", 64'(busy), 64'h0);

    // pslverr on SERIAL_1, then refresh against a healthy completer.
    set_completer(0, 32'h13631093, 32'h0000adbe, 32'hefc0def0, 32'hcafebabe,
                  8'hff, 0, 8'h10, 1'b0);
    do_reset();
    wait_for_end(200, cyc);
    check_output("recover.err_before", 64'(err), 64'h1);
    c_err_off = 8'hff;
    pulse_refresh();
    check_output("recover.err_cleared", 64'(err), 64'h0);
    check_output("recover.busy", 64'(busy), 64'h1);
    @(negedge pclk);
    refresh = 1'b0;
    wait_for_end(200, cyc);
    check_output("recover.cycle", 64'(cyc), 64'd11);
    check_output("recover.info_valid", 64'(info_valid), 64'h1);
    check_output("recover.err", 64'(err), 64'h0);
    check_output("recover.idcode", 64'(idcode), 64'h13631093);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
